board_renderer: RTL
===================

# board_renderer

Downstream consumer of the board storage block: on each `start` it scans all 256 grid cells in row-major order. For each cell it issues a read-mode access to storage, decodes the returned cell byte, and draws the cell as a `CELL_PX`×`CELL_PX` square through the VGA adapter's pixel-plot port, one pixel per clock. It owns the storage read port only while `busy` is high; arbitration against the game-step writer is external.

## Interface
- `CELL_PX`, 7: pixel edge length of one cell.
- `ORIGIN_X`, 24: screen x of cell (0,0) top-left pixel.
- `ORIGIN_Y`, 4: screen y of cell (0,0) top-left pixel.
- `READ_LAT`, 2: wait cycles from address issue to a valid `st_pos`/`st_cell`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low.
- `start`  in  1  pulse; begin a frame scan (ignored while `busy`).
- `busy`  out  1  high from the first ISSUE through DONE.
- `done`  out  1  one-cycle pulse when the frame is complete.
- `st_mode`  out  4  storage mode; constant 4'b0000 (read RAM).
- `st_address`  out  8  cell address {col[3:0], row[3:0]}.
- `st_load_out`  out  1  storage output-register load.
- `st_pos`  in  8  storage `updated_pos` (echoed address).
- `st_cell`  in  8  storage `updated_dir` (cell byte).
- `plot_x`  out  8  pixel x.
- `plot_y`  out  7  pixel y.
- `plot_colour`  out  3  RGB.
- `plot`  out  1  pixel write strobe.

## Operation
- Cell byte: bit7 wall, bit6 tank1, bit5 tank2, bit4 projectile, bits3:2 direction (00 up, 01 down, 10 left, 11 right).
- Base colour, by priority: wall 3'b111; else tank1 3'b100; else tank2 3'b001; else projectile 3'b110; else 3'b000.
- Barrel pixel: if tank1 or tank2 is set (and wall is not), the edge-midpoint pixel selected by direction is drawn 3'b111. Midpoint m = CELL_PX/2 (3). Up → (px=m, py=0); down → (m, CELL_PX−1); left → (0, m); right → (CELL_PX−1, m).
- Scan order: row 0..15 outer, col 0..15 inner. `st_address` = {col,row}.
- FSM states:
  - IDLE: `start` → ISSUE with col=row=0.
  - ISSUE: drive address, `st_load_out`=1 → WAIT.
  - WAIT: hold address, `st_load_out`=1 for READ_LAT cycles → CHECK.
  - CHECK: if `st_pos` == `st_address`, latch `st_cell` → PLOT with px=py=0. On mismatch → ISSUE (retry the same cell).
  - PLOT: `plot`=1 for each of the CELL_PX² pixels, px inner, py outer; after the last pixel → NEXT.
  - NEXT: advance col, wrapping to 0 and incrementing row. After cell (15,15) → DONE, otherwise → ISSUE.
  - DONE: `done`=1 → IDLE.
- Coordinates:
  - `plot_x` = ORIGIN_X + col·CELL_PX + px.
  - `plot_y` = ORIGIN_Y + row·CELL_PX + py.
  - Defaults give max x 135 and max y 115; no overflow.

## Timing
- Reset values: `busy`=0, `done`=0, `plot`=0, `st_load_out`=0, `st_mode`=0, `st_address`=0, `plot_x`=0, `plot_y`=0, `plot_colour`=0. All counters are 0 and the FSM is in IDLE.
- Reset mid-frame aborts immediately: the next cycle is IDLE with all outputs at reset values, and no `done` is produced.
- Per cell: 1 (ISSUE) + READ_LAT + 1 (CHECK) + CELL_PX² + 1 (NEXT) = 54 cycles at defaults. A frame with no retries takes 256·54 + 1 (DONE) = 13825 cycles from the first ISSUE.
- `plot_x`, `plot_y`, `plot_colour` are registered and valid in the same cycle as `plot`.
- `start` arriving in the DONE cycle is ignored. `start` arriving in IDLE is accepted the same cycle, so ISSUE occurs in the next cycle.
- `st_address` is stable from ISSUE through CHECK.

## Structure
- Shared package `tank_pkg` holds:
  - cell bit indices (WALL_B=7, T1_B=6, T2_B=5, PROJ_B=4, DIR_HI=3, DIR_LO=2);
  - direction codes;
  - storage mode codes (MODE_READ=4'b0000, MODE_EDIT=4'b1111, per-object modes);
  - colour constants;
  - the FSM state enum.
- One sub-module, `cell_pixel_colour`: combinational (cell byte, px, py) → colour, implementing the priority and barrel rules.

## Test plan
- Storage model with an all-zero board, READ_LAT=2, pulse `start`:
  - 12544 `plot` strobes, all colour 0;
  - first pixel at (24,4), last at (135,115);
  - `done` exactly 13825 cycles after the first ISSUE.
- Cell 0x00 = 8'b0100_0100 (tank1, down):
  - pixels (24..30, 4..10) are 3'b100, except (27,10) which is 3'b111.
- Cell {col=3,row=2} = 8'b1110_1100:
  - the wall wins, all 49 pixels are 3'b111, drawn at x 45..51, y 18..24.
- Storage echoes a wrong `st_pos` once for cell 5:
  - the renderer re-issues cell 5;
  - no pixels are plotted for the bad sample;
  - the total frame length grows by exactly READ_LAT+2 cycles.
- Assert `reset`=0 during PLOT of cell 100:
  - the next cycle has `plot`=0 and `busy`=0, and all outputs are 0;
  - a subsequent `start` restarts at cell (0,0).
- `start` pulsed while `busy`: no effect on the scan and no second `done`.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared definitions for the tank game: cell byte layout, storage modes,
// palette and the board renderer state encoding.
package tank_pkg;

    localparam int unsigned WALL_B = 7;
    localparam int unsigned T1_B   = 6;
    localparam int unsigned T2_B   = 5;
    localparam int unsigned PROJ_B = 4;
    localparam int unsigned DIR_HI = 3;
    localparam int unsigned DIR_LO = 2;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [3:0] MODE_READ  = 4'b0000;
    localparam logic [3:0] MODE_EDIT  = 4'b1111;
    localparam logic [3:0] MODE_WALL  = 4'b0001;
    localparam logic [3:0] MODE_TANK1 = 4'b0010;
    localparam logic [3:0] MODE_TANK2 = 4'b0100;
    localparam logic [3:0] MODE_PROJ  = 4'b1000;

    localparam logic [2:0] COL_WALL   = 3'b111;
    localparam logic [2:0] COL_TANK1  = 3'b100;
    localparam logic [2:0] COL_TANK2  = 3'b001;
    localparam logic [2:0] COL_PROJ   = 3'b110;
    localparam logic [2:0] COL_EMPTY  = 3'b000;
    localparam logic [2:0] COL_BARREL = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_PLOT  = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } rend_state_e;

endpackage

// File: rtl/cell_pixel_colour.sv
// Colour of one pixel inside a cell square: object priority plus the
// white barrel pixel on the tank's facing edge.
module cell_pixel_colour
    import tank_pkg::*;
#(
    parameter int unsigned CELL_PX = 7,
    parameter int unsigned PX_W    = 3
) (
    input  logic [7:0]      i_cell,
    input  logic [PX_W-1:0] i_px,
    input  logic [PX_W-1:0] i_py,
    output logic [2:0]      o_colour_c
);

    localparam logic [PX_W-1:0] P_MID  = PX_W'(CELL_PX / 2);
    localparam logic [PX_W-1:0] P_LAST = PX_W'(CELL_PX - 1);

    logic [1:0] w_dir;
    logic       w_tank;
    logic       w_barrel;
    logic       w_unused_bits;

    assign w_dir         = i_cell[DIR_HI:DIR_LO];
    assign w_tank        = i_cell[T1_B] | i_cell[T2_B];
    assign w_unused_bits = ^i_cell[1:0];

    always_comb begin
        w_barrel = 1'b0;
        case (w_dir)
            DIR_UP:    w_barrel = (i_px == P_MID)  && (i_py == '0);
            DIR_DOWN:  w_barrel = (i_px == P_MID)  && (i_py == P_LAST);
            DIR_LEFT:  w_barrel = (i_px == '0)     && (i_py == P_MID);
            DIR_RIGHT: w_barrel = (i_px == P_LAST) && (i_py == P_MID);
            default:   w_barrel = 1'b0;
        endcase
    end

    // Wall hides everything, including a barrel.
    always_comb begin
        o_colour_c = COL_EMPTY;
        if (i_cell[WALL_B])          o_colour_c = COL_WALL;
        else if (w_tank && w_barrel) o_colour_c = COL_BARREL;
        else if (i_cell[T1_B])       o_colour_c = COL_TANK1;
        else if (i_cell[T2_B])       o_colour_c = COL_TANK2;
        else if (i_cell[PROJ_B])     o_colour_c = COL_PROJ;
    end

endmodule

// File: rtl/board_renderer.sv
// Scans the 16x16 board from storage and plots each cell as a square on
// the VGA pixel port, one pixel per clock.
module board_renderer
    import tank_pkg::*;
#(
    parameter int unsigned CELL_PX  = 7,
    parameter int unsigned ORIGIN_X = 24,
    parameter int unsigned ORIGIN_Y = 4,
    parameter int unsigned READ_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [3:0] st_mode,
    output logic [7:0] st_address,
    output logic       st_load_out,
    input  logic [7:0] st_pos,
    input  logic [7:0] st_cell,
    output logic [7:0] plot_x,
    output logic [6:0] plot_y,
    output logic [2:0] plot_colour,
    output logic       plot
);

    localparam int unsigned PX_W   = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
    localparam int unsigned WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    rend_state_e       r_state, w_state_n;
    logic [3:0]        r_col, w_col_n;
    logic [3:0]        r_row, w_row_n;
    logic [PX_W-1:0]   r_px, w_px_n;
    logic [PX_W-1:0]   r_py, w_py_n;
    logic [WAIT_W-1:0] r_wait, w_wait_n;
    logic [7:0]        r_cell, w_cell_n;

    logic       w_busy_n;
    logic       w_done_n;
    logic       w_load_n;
    logic [7:0] w_addr_n;
    logic       w_plot_n;
    logic [7:0] w_x_n;
    logic [6:0] w_y_n;
    logic [2:0] w_colour_c;
    logic [2:0] w_colour_n;

    always_comb begin
        w_state_n = r_state;
        w_col_n   = r_col;
        w_row_n   = r_row;
        w_px_n    = r_px;
        w_py_n    = r_py;
        w_wait_n  = r_wait;
        w_cell_n  = r_cell;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_n = ST_ISSUE;
                    w_col_n   = '0;
                    w_row_n   = '0;
                end
            end
            ST_ISSUE: begin
                w_wait_n  = '0;
                w_state_n = (READ_LAT == 0) ? ST_CHECK : ST_WAIT;
            end
            ST_WAIT: begin
                if (r_wait == WAIT_W'(READ_LAT - 1)) w_state_n = ST_CHECK;
                else                                  w_wait_n  = r_wait + 1'b1;
            end
            // A stale or foreign echo means the read was not ours: reissue it.
            ST_CHECK: begin
                if (st_pos == st_address) begin
                    w_cell_n  = st_cell;
                    w_px_n    = '0;
                    w_py_n    = '0;
                    w_state_n = ST_PLOT;
                end else begin
                    w_state_n = ST_ISSUE;
                end
            end
            ST_PLOT: begin
                if (r_px == PX_W'(CELL_PX - 1)) begin
                    w_px_n = '0;
                    if (r_py == PX_W'(CELL_PX - 1)) w_state_n = ST_NEXT;
                    else                            w_py_n    = r_py + 1'b1;
                end else begin
                    w_px_n = r_px + 1'b1;
                end
            end
            ST_NEXT: begin
                w_state_n = ST_ISSUE;
                if (r_col == 4'd15) begin
                    w_col_n = '0;
                    w_row_n = r_row + 4'd1;
                    if (r_row == 4'd15) w_state_n = ST_DONE;
                end else begin
                    w_col_n = r_col + 4'd1;
                end
            end
            ST_DONE:  w_state_n = ST_IDLE;
            default:  w_state_n = ST_IDLE;
        endcase

        w_busy_n = (w_state_n != ST_IDLE);
        w_done_n = (w_state_n == ST_DONE);
        w_load_n = (w_state_n == ST_ISSUE) || (w_state_n == ST_WAIT);
        w_addr_n = {w_col_n, w_row_n};
        w_plot_n = (w_state_n == ST_PLOT);
    end

    cell_pixel_colour #(
        .CELL_PX (CELL_PX),
        .PX_W    (PX_W)
    ) u_colour (
        .i_cell     (w_cell_n),
        .i_px       (w_px_n),
        .i_py       (w_py_n),
        .o_colour_c (w_colour_c)
    );

    // Pixel outputs are computed from next-state counters so they register
    // alongside the plot strobe.
    assign w_x_n = w_plot_n ? 8'(ORIGIN_X) + 8'(w_col_n) * 8'(CELL_PX) + 8'(w_px_n) : 8'd0;
    assign w_y_n = w_plot_n ? 7'(ORIGIN_Y) + 7'(w_row_n) * 7'(CELL_PX) + 7'(w_py_n) : 7'd0;
    assign w_colour_n = w_plot_n ? w_colour_c : COL_EMPTY;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_px        <= '0;
            r_py        <= '0;
            r_wait      <= '0;
            r_cell      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            st_mode     <= MODE_READ;
            st_address  <= '0;
            st_load_out <= 1'b0;
            plot_x      <= '0;
            plot_y      <= '0;
            plot_colour <= '0;
            plot        <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_col       <= w_col_n;
            r_row       <= w_row_n;
            r_px        <= w_px_n;
            r_py        <= w_py_n;
            r_wait      <= w_wait_n;
            r_cell      <= w_cell_n;
            busy        <= w_busy_n;
            done        <= w_done_n;
            st_mode     <= MODE_READ;
            st_address  <= w_addr_n;
            st_load_out <= w_load_n;
            plot_x      <= w_x_n;
            plot_y      <= w_y_n;
            plot_colour <= w_colour_n;
            plot        <= w_plot_n;
        end
    end

endmodule
